// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_MIPS32 program loader: FSM state encoding,
// framing byte defaults and memory geometry.
package mips32_pkg;

  // Unified memory size in 32-bit words.
  localparam int MEM_WORDS = 1024;

  // Default framing bytes.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] GO_BYTE_DEF   = 8'h5A;

  // Halt opcode of the core; a loaded program is expected to end with it.
  localparam logic [5:0] OP_HLT = 6'h3F;

  // Loader FSM states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA,
    ST_CSUM
  } loader_state_t;

endpackage

// File: rtl/mips32_word_packer.sv
// Packs accepted data bytes (MSB first) into 32-bit words and emits a
// one-cycle word_valid pulse in the cycle after the fourth byte.
module mips32_word_packer (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_reg;
  logic [23:0] shift_reg;
  logic        valid_reg;
  logic [31:0] word_reg;

  // The byte being presented now completes a word.
  assign last_byte  = (idx_reg == 2'd3);
  assign word_valid = valid_reg;
  assign word       = word_reg;

  // Byte index, shift register and registered word-complete pulse.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      idx_reg   <= 2'd0;
      shift_reg <= 24'd0;
      valid_reg <= 1'b0;
      word_reg  <= 32'd0;
    end else begin
      valid_reg <= 1'b0;
      if (clear) begin
        // Drop any partial word; a stale index must never leak into a new frame.
        idx_reg <= 2'd0;
      end else if (byte_valid) begin
        idx_reg <= idx_reg + 2'd1;
        if (idx_reg == 2'd3) begin
          word_reg  <= {shift_reg, byte_in};
          valid_reg <= 1'b1;
        end else begin
          shift_reg <= {shift_reg[15:0], byte_in};
        end
      end
    end
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader: parses SYNC/ADDR/CNT/DATA/CSUM frames, writes
// packed words into the core's unified memory and holds the core until GO.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int         ADDR_W      = $clog2(MEM_WORDS),
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [7:0] GO_BYTE     = GO_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  loader_state_t     state_reg, state_next;
  logic              ready_reg;
  logic              hold_reg, hold_next;
  logic              err_reg, err_next;
  logic [7:0]        addr_h_reg, addr_h_next;
  logic [ADDR_W-1:0] addr_cnt_reg, addr_cnt_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        cnt_h_reg, cnt_h_next;
  logic [15:0]       words_left_reg, words_left_next;
  logic [7:0]        csum_reg, csum_next;
  logic [TO_W-1:0]   to_cnt_reg;

  logic              accept;
  logic              timeout;
  logic              data_byte;
  logic              last_byte;
  logic              packer_clear;
  logic [15:0]       base_full;
  logic [15:0]       cnt_full;

  assign accept    = s_valid && ready_reg;
  assign timeout   = (state_reg != ST_IDLE) && !accept &&
                     (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
  assign data_byte = accept && (state_reg == ST_DATA);
  // Packer restarts in IDLE and on abort, so no partial word survives.
  assign packer_clear = timeout || (state_reg == ST_IDLE);
  assign base_full = {addr_h_reg, s_data};
  assign cnt_full  = {cnt_h_reg, s_data};

  assign s_ready  = ready_reg;
  assign mem_addr = mem_addr_reg;
  assign cpu_hold = hold_reg;
  assign err      = err_reg;
  assign busy     = (state_reg != ST_IDLE);

  mips32_word_packer u_packer (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clear      (packer_clear),
    .byte_valid (data_byte),
    .byte_in    (s_data),
    .last_byte  (last_byte),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  // Next-state and frame-field decode; timeout overrides any byte handling.
  always_comb begin
    state_next      = state_reg;
    hold_next       = hold_reg;
    err_next        = err_reg;
    addr_h_next     = addr_h_reg;
    addr_cnt_next   = addr_cnt_reg;
    mem_addr_next   = mem_addr_reg;
    cnt_h_next      = cnt_h_reg;
    words_left_next = words_left_reg;
    csum_next       = csum_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (s_data == SYNC_BYTE) begin
            state_next = ST_ADDR_H;
            hold_next  = 1'b1;
            err_next   = 1'b0;
            csum_next  = 8'd0;
          end else if (s_data == GO_BYTE) begin
            if (!err_reg) hold_next = 1'b0;
          end
        end
      end
      ST_ADDR_H: begin
        if (accept) begin
          addr_h_next = s_data;
          state_next  = ST_ADDR_L;
        end
      end
      ST_ADDR_L: begin
        if (accept) begin
          addr_cnt_next = base_full[ADDR_W-1:0];
          state_next    = ST_CNT_H;
        end
      end
      ST_CNT_H: begin
        if (accept) begin
          cnt_h_next = s_data;
          state_next = ST_CNT_L;
        end
      end
      ST_CNT_L: begin
        if (accept) begin
          words_left_next = cnt_full;
          state_next      = (cnt_full == 16'd0) ? ST_CSUM : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          csum_next = csum_reg ^ s_data;
          if (last_byte) begin
            // Address wraps naturally at the top of memory.
            mem_addr_next   = addr_cnt_reg;
            addr_cnt_next   = addr_cnt_reg + ADDR_W'(1);
            words_left_next = words_left_reg - 16'd1;
            if (words_left_reg == 16'd1) state_next = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (s_data != csum_reg) err_next = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (timeout) begin
      err_next   = 1'b1;
      state_next = ST_IDLE;
    end
  end

  // State, control flags and frame registers.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      ready_reg      <= 1'b0;
      hold_reg       <= 1'b1;
      err_reg        <= 1'b0;
      addr_h_reg     <= 8'd0;
      addr_cnt_reg   <= '0;
      mem_addr_reg   <= '0;
      cnt_h_reg      <= 8'd0;
      words_left_reg <= 16'd0;
      csum_reg       <= 8'd0;
    end else begin
      state_reg      <= state_next;
      ready_reg      <= 1'b1;
      hold_reg       <= hold_next;
      err_reg        <= err_next;
      addr_h_reg     <= addr_h_next;
      addr_cnt_reg   <= addr_cnt_next;
      mem_addr_reg   <= mem_addr_next;
      cnt_h_reg      <= cnt_h_next;
      words_left_reg <= words_left_next;
      csum_reg       <= csum_next;
    end
  end

  // Idle-gap counter: restarts on every accepted byte and whenever IDLE is entered.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (accept || state_next == ST_IDLE) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Self-checking bench for mips32_prog_loader: directed frames from the
// datasheet examples plus randomized frames checked against a frame-level model.
module tb_mips32_prog_loader;

  localparam int ADDR_W      = 10;
  localparam int TIMEOUT_CYC = 4096;
  localparam int MEM_SIZE    = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              err;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [31:0]       exp_data[$];
  logic [7:0]        bytes_q[$];
  logic              exp_err;
  logic              exp_hold;

  mips32_prog_loader #(
    .ADDR_W      (ADDR_W),
    .SYNC_BYTE   (8'hA5),
    .GO_BYTE     (8'h5A),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk1 = ~clk1;

  // Log every write strobe seen mid-cycle.
  always @(negedge clk1) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      $display("WRITE addr=%03h data=%08h", mem_addr, mem_data_str(mem_wdata));
    end
  end

  function automatic logic [31:0] mem_data_str(input logic [31:0] d);
    return d;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk1);
    #1;
    s_valid = 1'b0;
    $display("BYTE %02h busy=%0b err=%0b hold=%0b", b, busy, err, cpu_hold);
  endtask

  task automatic send_list(input int gap_max);
    foreach (bytes_q[i]) begin
      send_byte(bytes_q[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk1);
      #0;
    end
    bytes_q.delete();
  endtask

  task automatic settle_and_clear_expect();
    repeat (3) @(posedge clk1);
    #1;
  endtask

  task automatic drop_logs();
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  // Model of one frame: writes go to consecutive addresses modulo memory size,
  // err reflects whether the sent checksum equals the XOR of all data bytes.
  task automatic send_frame(input logic [15:0] base, input int cnt,
                            input bit corrupt, input int gap_max);
    logic [7:0]  x;
    logic [31:0] w;
    logic [7:0]  cs;
    logic [15:0] cnt16;
    cnt16 = 16'(cnt);
    x = 8'h00;
    bytes_q.push_back(8'hA5);
    bytes_q.push_back(base[15:8]);
    bytes_q.push_back(base[7:0]);
    bytes_q.push_back(cnt16[15:8]);
    bytes_q.push_back(cnt16[7:0]);
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      exp_addr.push_back(ADDR_W'((int'(base) + i) % MEM_SIZE));
      exp_data.push_back(w);
      for (int k = 3; k >= 0; k--) begin
        bytes_q.push_back(w[8*k +: 8]);
        x = x ^ w[8*k +: 8];
      end
    end
    cs = corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x;
    bytes_q.push_back(cs);
    send_list(gap_max);
    exp_hold = 1'b1;
    exp_err  = (cs != x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    checks++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, err} !==
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got ready=%b we=%b addr=%h data=%h hold=%b busy=%b err=%b want 0 0 000 00000000 1 0 0",
               s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, err);
    end
    rst_n = 1'b1;
    @(posedge clk1);
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got %b want 1", s_ready);
    end
    exp_err = 1'b0;
    exp_hold = 1'b1;
    drop_logs();
  endtask

  task automatic test_idle_bytes();
    send_byte(8'h33);
    checks++;
    if ({busy, err, cpu_hold} !== 3'b001) begin
      failures++;
      $display("FAIL stray_byte got busy=%b err=%b hold=%b want 0 0 1", busy, err, cpu_hold);
    end
    send_byte(8'h5A);
    exp_hold = 1'b0;
    checks++;
    if ({busy, cpu_hold} !== 2'b00) begin
      failures++;
      $display("FAIL go_after_reset got busy=%b hold=%b want 0 0", busy, cpu_hold);
    end
  endtask

  task automatic test_spec_frame();
    bytes_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h78,
                8'h0C, 8'h63, 8'h18, 8'h00, 8'h26};
    send_list(0);
    exp_addr = '{10'h000, 10'h001};
    exp_data = '{32'h28010078, 32'h0C631800};
    settle_and_clear_expect();
    checks++;
    if (got_addr.size() != 2) begin
      failures++;
      $display("FAIL spec_frame_count got %0d want 2", got_addr.size());
    end
    foreach (exp_addr[i]) begin
      checks++;
      if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL spec_frame_write%0d want %h=%h", i, exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if ({busy, err, cpu_hold} !== 3'b001) begin
      failures++;
      $display("FAIL spec_frame_flags got busy=%b err=%b hold=%b want 0 0 1", busy, err, cpu_hold);
    end
    drop_logs();
  endtask

  task automatic test_bad_csum();
    bytes_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h78,
                8'h0C, 8'h63, 8'h18, 8'h00, 8'h27};
    send_list(0);
    settle_and_clear_expect();
    checks++;
    if (got_addr.size() != 2 || err !== 1'b1) begin
      failures++;
      $display("FAIL bad_csum got writes=%0d err=%b want writes=2 err=1", got_addr.size(), err);
    end
    send_byte(8'h5A);
    checks++;
    if (cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL go_blocked_by_err got hold=%b want 1", cpu_hold);
    end
    drop_logs();
    send_frame(16'h0100, 1, 1'b0, 0);
    settle_and_clear_expect();
    checks++;
    if (err !== 1'b0 || got_addr.size() != 1 || got_data[0] !== exp_data[0]) begin
      failures++;
      $display("FAIL recover_frame got err=%b writes=%0d want err=0 writes=1", err, got_addr.size());
    end
    send_byte(8'h5A);
    exp_hold = 1'b0;
    checks++;
    if (cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL go_after_recover got hold=%b want 0", cpu_hold);
    end
    drop_logs();
  endtask

  task automatic test_wrap();
    logic [31:0] w0, w1;
    logic [7:0]  x;
    w0 = $urandom;
    w1 = $urandom;
    x = w0[31:24] ^ w0[23:16] ^ w0[15:8] ^ w0[7:0] ^ w1[31:24] ^ w1[23:16] ^ w1[15:8] ^ w1[7:0];
    bytes_q = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, w0[31:24], w0[23:16], w0[15:8], w0[7:0],
                w1[31:24], w1[23:16], w1[15:8], w1[7:0], x};
    send_list(0);
    settle_and_clear_expect();
    checks++;
    if (got_addr.size() != 2) begin
      failures++;
      $display("FAIL wrap_count got %0d want 2", got_addr.size());
    end else begin
      checks++;
      if (got_addr[0] !== 10'h3FF || got_addr[1] !== 10'h000 || got_data[0] !== w0 || got_data[1] !== w1) begin
        failures++;
        $display("FAIL wrap_writes got %h=%h %h=%h want 3ff=%h 000=%h",
                 got_addr[0], got_data[0], got_addr[1], got_data[1], w0, w1);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_err got %b want 0", err);
    end
    exp_hold = 1'b1;
    drop_logs();
  endtask

  task automatic test_cnt_zero();
    bytes_q = '{8'hA5, 8'h00, 8'h78, 8'h00, 8'h00, 8'h00};
    send_list(0);
    settle_and_clear_expect();
    checks++;
    if (got_addr.size() != 0 || err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cnt_zero_ok got writes=%0d err=%b busy=%b want 0 0 0", got_addr.size(), err, busy);
    end
    bytes_q = '{8'hA5, 8'h00, 8'h78, 8'h00, 8'h00, 8'h01};
    send_list(0);
    settle_and_clear_expect();
    checks++;
    if (got_addr.size() != 0 || err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cnt_zero_bad got writes=%0d err=%b busy=%b want 0 1 0", got_addr.size(), err, busy);
    end
    drop_logs();
  endtask

  task automatic test_timeout();
    bytes_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'hDE, 8'hAD};
    send_list(0);
    repeat (TIMEOUT_CYC - 1) @(posedge clk1);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early got busy=%b want 1", busy);
    end
    @(posedge clk1);
    #1;
    checks++;
    if ({busy, err} !== 2'b01 || got_addr.size() != 0) begin
      failures++;
      $display("FAIL timeout_abort got busy=%b err=%b writes=%0d want 0 1 0", busy, err, got_addr.size());
    end
    send_frame(16'h0010, 2, 1'b0, 0);
    settle_and_clear_expect();
    checks++;
    if (got_addr.size() != 2 || err !== 1'b0) begin
      failures++;
      $display("FAIL after_timeout got writes=%0d err=%b want 2 0", got_addr.size(), err);
    end
    foreach (exp_addr[i]) begin
      checks++;
      if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL after_timeout_write%0d want %h=%h", i, exp_addr[i], exp_data[i]);
      end
    end
    drop_logs();
  endtask

  task automatic test_reset_mid();
    bytes_q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    send_list(0);
    s_valid = 1'b1;
    s_data  = 8'h44;
    rst_n   = 1'b0;
    @(posedge clk1);
    #1;
    s_valid = 1'b0;
    checks++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, err} !==
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got ready=%b we=%b addr=%h data=%h hold=%b busy=%b err=%b want 0 0 000 00000000 1 0 0",
               s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, err);
    end
    rst_n = 1'b1;
    settle_and_clear_expect();
    checks++;
    if (got_addr.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_nowrite got writes=%0d want 0", got_addr.size());
    end
    exp_err = 1'b0;
    exp_hold = 1'b1;
    drop_logs();
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5 || b == 8'h5A) b = 8'h00;
        send_byte(b);
      end
      send_frame(16'($urandom), $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
                 (it % 2 == 0) ? 0 : 3);
      if ($urandom_range(0, 1) == 1) begin
        send_byte(8'h5A);
        if (!exp_err) exp_hold = 1'b0;
      end
      settle_and_clear_expect();
      checks++;
      if (got_addr.size() != exp_addr.size()) begin
        failures++;
        $display("FAIL rand%0d_count got %0d want %0d", it, got_addr.size(), exp_addr.size());
      end
      foreach (exp_addr[i]) begin
        checks++;
        if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          failures++;
          $display("FAIL rand%0d_write%0d want %h=%h", it, i, exp_addr[i], exp_data[i]);
        end
      end
      checks++;
      if ({busy, err, cpu_hold} !== {1'b0, exp_err, exp_hold}) begin
        failures++;
        $display("FAIL rand%0d_flags got busy=%b err=%b hold=%b want 0 %b %b",
                 it, busy, err, cpu_hold, exp_err, exp_hold);
      end
      drop_logs();
    end
  endtask

  initial begin
    test_reset();
    test_idle_bytes();
    test_spec_frame();
    test_bad_csum();
    test_wrap();
    test_cnt_zero();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop so a stuck run still terminates with a report.
  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "simulation time limit");
  end

endmodule
